// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: writeback requests, issue/decode sideband and register-file write port
interface regfile_wb_sched_if;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        iss_valid, stall, we_rd;
  logic [4:0]  iss_rd, rs1_addr, rs2_addr, a_rd;
  logic [31:0] d_rd;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, stall, a_rd, d_rd, we_rd
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_valid, iss_rd, rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, stall, a_rd, d_rd, we_rd
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: round-robin ALU/LSU writeback arbiter driving the register-file write port;
// define WBSCHED_SCOREBOARD_EN to add the busy scoreboard and decode stall.
module regfile_wb_sched (
  input  logic              clk,
  input  logic              resetb,
  regfile_wb_sched_if.slave wb
);
  logic        last_lsu_q, last_lsu_d;
  logic        gnt_alu, gnt_lsu, we;
  logic [4:0]  g_rd;
  logic [31:0] g_data;
  always_comb begin
    gnt_alu    = resetb && wb.alu_valid && (!wb.lsu_valid || last_lsu_q);
    gnt_lsu    = resetb && wb.lsu_valid && !gnt_alu;
    g_rd       = gnt_alu ? wb.alu_rd : wb.lsu_rd;
    g_data     = gnt_alu ? wb.alu_data : wb.lsu_data;
    we         = (gnt_alu || gnt_lsu) && g_rd != 5'd0;
    last_lsu_d = (wb.alu_valid && wb.lsu_valid) ? gnt_lsu : last_lsu_q;
  end
  always_ff @(posedge clk) last_lsu_q <= !resetb ? 1'b1 : last_lsu_d;
  assign wb.alu_ready = gnt_alu;
  assign wb.lsu_ready = gnt_lsu;
  assign wb.we_rd     = we;
  assign wb.a_rd      = we ? g_rd : 5'd0;
  assign wb.d_rd      = we ? g_data : 32'd0;
`ifdef WBSCHED_SCOREBOARD_EN
  logic [31:1] busy_q, busy_d;
  logic [31:0] busy_v;
  logic        stall, set_en;
  // a source whose write lands this cycle is forwarded by the register file
  always_comb begin
    busy_v = {busy_q, 1'b0};
    stall  = resetb && ((busy_v[wb.rs1_addr] && !(we && g_rd == wb.rs1_addr)) ||
                        (busy_v[wb.rs2_addr] && !(we && g_rd == wb.rs2_addr)));
    set_en = wb.iss_valid && !stall;
    for (int i = 1; i < 32; i++)
      busy_d[i] = (set_en && wb.iss_rd == 5'(i)) || (busy_q[i] && !(we && g_rd == 5'(i)));
  end
  always_ff @(posedge clk) busy_q <= !resetb ? '0 : busy_d;
`else
  logic stall, unused_sb;
  assign stall     = 1'b0;
  assign unused_sb = ^{wb.iss_valid, wb.iss_rd, wb.rs1_addr, wb.rs2_addr};
`endif
  assign wb.stall = stall;
endmodule
